// File: rtl/nrisc_pkg.sv
// Shared encodings for the nRisc memory arbiter: FSM states, access owner, counter sizing.
package nrisc_pkg;
  localparam int LAT_MAX = 7;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;
endpackage

// File: rtl/nrisc_mem_arbiter_if.sv
// Bus bundle between the nRisc core (fetch + data ports), the arbiter and the shared memory.
interface nrisc_mem_arbiter_if #(
  parameter int W_ADDR = 8,
  parameter int W_DATA = 8
);
  logic              if_req;
  logic [W_ADDR-1:0] if_addr;
  logic [W_DATA-1:0] if_rdata;
  logic              if_valid;
  logic              dm_rd;
  logic              dm_wr;
  logic [W_ADDR-1:0] dm_addr;
  logic [W_DATA-1:0] dm_wdata;
  logic [W_DATA-1:0] dm_rdata;
  logic              dm_done;
  logic              encerra;
  logic              halted;
  logic              stall;
  logic              proto_err;
  logic              mem_en;
  logic              mem_we;
  logic [W_ADDR-1:0] mem_addr;
  logic [W_DATA-1:0] mem_wdata;
  logic [W_DATA-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, encerra, mem_rdata,
    output if_rdata, if_valid, dm_rdata, dm_done, halted, stall, proto_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, encerra, mem_rdata,
    input  if_rdata, if_valid, dm_rdata, dm_done, halted, stall, proto_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/nrisc_lat_counter.sv
// Read-latency counter: load to 1 on issue, count while waiting, flag when LAT is reached.
module nrisc_lat_counter
  import nrisc_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic load,
  input  logic inc,
  output logic term
);
  logic [CNT_W-1:0] cnt;

  // Holding at the terminal value keeps LAT_MAX from wrapping the 3-bit count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)          cnt <= '0;
    else if (load)         cnt <= CNT_W'(1);
    else if (inc && !term) cnt <= cnt + CNT_W'(1);
  end

  assign term = (cnt == CNT_W'(LAT));
endmodule

// File: rtl/nrisc_mem_arbiter.sv
// Single-port memory arbiter for nRisc: data access beats instruction fetch, one access in flight.
module nrisc_mem_arbiter
  import nrisc_pkg::*;
#(
  parameter int LAT    = 1,
  parameter int W_ADDR = 8,
  parameter int W_DATA = 8
) (
  input logic                clock,
  input logic                reset_n,
  nrisc_mem_arbiter_if.slave bus
);
  state_t            state, stateNxt;
  owner_t            owner;
  logic              latWe;
  logic [W_ADDR-1:0] latAddr;
  logic [W_DATA-1:0] latWdata, ifRdata, dmRdata;
  logic              protoErr, term, dmReq;
  logic              grant, cntLoad, cntInc, capture;

  assign dmReq = bus.dm_rd | bus.dm_wr;

  nrisc_lat_counter #(.LAT(LAT)) uCnt (
    .clock  (clock),
    .reset_n(reset_n),
    .load   (cntLoad),
    .inc    (cntInc),
    .term   (term)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    grant    = 1'b0;
    cntLoad  = 1'b0;
    cntInc   = 1'b0;
    capture  = 1'b0;
    case (state)
      IDLE: if (dmReq || (bus.if_req && !bus.encerra)) begin
        grant    = 1'b1;
        stateNxt = ISSUE;
      end
      ISSUE: begin
        cntLoad  = 1'b1;
        stateNxt = WAIT;
      end
      WAIT: begin
        cntInc = 1'b1;
        if (term) begin
          capture  = 1'b1;
          stateNxt = RESP;
        end
      end
      RESP:    stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  // Requester inputs are sampled only at grant; later changes are ignored until RESP.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      owner    <= OWN_IF;
      latWe    <= 1'b0;
      latAddr  <= '0;
      latWdata <= '0;
      ifRdata  <= '0;
      dmRdata  <= '0;
      protoErr <= 1'b0;
    end else begin
      if (bus.dm_rd && bus.dm_wr) protoErr <= 1'b1;
      if (grant) begin
        owner    <= dmReq ? OWN_DM : OWN_IF;
        latWe    <= bus.dm_wr;
        latAddr  <= dmReq ? bus.dm_addr : bus.if_addr;
        latWdata <= dmReq ? bus.dm_wdata : '0;
      end
      if (capture) begin
        if (owner == OWN_IF) ifRdata <= bus.mem_rdata;
        else if (!latWe)     dmRdata <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_en    = (state == ISSUE);
  assign bus.mem_we    = (state == ISSUE) && latWe;
  assign bus.mem_addr  = latAddr;
  assign bus.mem_wdata = latWdata;
  assign bus.if_valid  = (state == RESP) && (owner == OWN_IF);
  assign bus.dm_done   = (state == RESP) && (owner == OWN_DM);
  assign bus.if_rdata  = ifRdata;
  assign bus.dm_rdata  = dmRdata;
  assign bus.proto_err = protoErr;
  assign bus.halted    = bus.encerra && (state == IDLE);
  assign bus.stall     = (bus.if_req | dmReq) & ~(bus.if_valid | bus.dm_done);
endmodule

// File: tb/tb_nrisc_mem_arbiter.sv
// Bench for nrisc_mem_arbiter: two instances (LAT=1, LAT=4), per-cycle transaction-level model plus directed checks.
module tb_nrisc_mem_arbiter;
  typedef struct {
    logic       rstN, ifReq, dmRd, dmWr, enc;
    logic [7:0] ifAddr, dmAddr, dmWdata;
    logic       ifValid, dmDone, halted, stall, protoErr, memEn, memWe;
    logic [7:0] ifRdata, dmRdata, memAddr, memWdata;
  } obs_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int cyc;
  always @(posedge clock) cyc <= cyc + 1;

  int checks;
  int failures;

  logic [1:0] rstN, ifReq, dmRd, dmWr, enc;
  logic [7:0] ifAddr [2];
  logic [7:0] dmAddr [2];
  logic [7:0] dmWdata [2];

  logic [1:0] ifValidV, dmDoneV, haltedV, stallV, protoErrV, memEnV, memWeV;
  logic [7:0] ifRdataV [2];
  logic [7:0] dmRdataV [2];
  logic [7:0] memAddrV [2];

  // Transaction-level model state, one slot per instance.
  bit         mActive [2];
  int         mGrant  [2];
  bit         mOwnDm  [2];
  bit         mWe     [2];
  logic [7:0] mAddr   [2];
  logic [7:0] mWdata  [2];
  logic [7:0] mIfR    [2];
  logic [7:0] mDmR    [2];
  bit         mErr    [2];
  logic [7:0] mdlMem  [2][256];

  function automatic logic [7:0] initVal(input logic [7:0] a);
    case (a)
      8'h10:   return 8'hA5;
      8'h20:   return 8'h3C;
      8'h40:   return 8'h4D;
      default: return a ^ 8'h5A;
    endcase
  endfunction

  task automatic chk1(input string name, input int i, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d cyc=%0d got=%0b exp=%0b", name, i, cyc, act, exp);
    end
  endtask

  task automatic chk8(input string name, input int i, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d cyc=%0d got=%02h exp=%02h", name, i, cyc, act, exp);
    end
  endtask

  task automatic chkI(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  // Model: grant at IDLE cycle c -> strobe at c+1, completion at c+lat+2, free again at c+lat+3.
  task automatic step(input int i, input int lat, input int c, input obs_t o);
    bit issue, done;
    if (!o.rstN) begin
      mActive[i] = 0; mIfR[i] = '0; mDmR[i] = '0; mErr[i] = 0;
      chk1("rst_if_valid", i, o.ifValid, 1'b0);
      chk1("rst_dm_done", i, o.dmDone, 1'b0);
      chk8("rst_if_rdata", i, o.ifRdata, 8'h00);
      chk8("rst_dm_rdata", i, o.dmRdata, 8'h00);
      chk1("rst_mem_en", i, o.memEn, 1'b0);
      chk1("rst_mem_we", i, o.memWe, 1'b0);
      chk8("rst_mem_addr", i, o.memAddr, 8'h00);
      chk8("rst_mem_wdata", i, o.memWdata, 8'h00);
      chk1("rst_proto_err", i, o.protoErr, 1'b0);
      return;
    end
    issue = mActive[i] && (c == mGrant[i] + 1);
    done  = mActive[i] && (c == mGrant[i] + lat + 2);
    if (done) begin
      if (!mOwnDm[i])  mIfR[i] = mdlMem[i][mAddr[i]];
      else if (!mWe[i]) mDmR[i] = mdlMem[i][mAddr[i]];
    end
    chk1("if_valid", i, o.ifValid, done && !mOwnDm[i]);
    chk1("dm_done", i, o.dmDone, done && mOwnDm[i]);
    chk8("if_rdata", i, o.ifRdata, mIfR[i]);
    chk8("dm_rdata", i, o.dmRdata, mDmR[i]);
    chk1("mem_en", i, o.memEn, issue);
    chk1("mem_we", i, o.memWe, issue && mWe[i]);
    if (issue) chk8("mem_addr", i, o.memAddr, mAddr[i]);
    if (issue && mWe[i]) chk8("mem_wdata", i, o.memWdata, mWdata[i]);
    chk1("halted", i, o.halted, o.enc && !mActive[i]);
    chk1("stall", i, o.stall, (o.ifReq || o.dmRd || o.dmWr) && !done);
    chk1("proto_err", i, o.protoErr, mErr[i]);
    if (o.dmRd && o.dmWr) mErr[i] = 1;
    if (done) mActive[i] = 0;
    else if (!mActive[i]) begin
      if (o.dmRd || o.dmWr) begin
        mActive[i] = 1; mGrant[i] = c; mOwnDm[i] = 1; mWe[i] = o.dmWr;
        mAddr[i] = o.dmAddr; mWdata[i] = o.dmWdata;
        if (o.dmWr) mdlMem[i][o.dmAddr] = o.dmWdata;
      end else if (o.ifReq && !o.enc) begin
        mActive[i] = 1; mGrant[i] = c; mOwnDm[i] = 0; mWe[i] = 0; mAddr[i] = o.ifAddr;
      end
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gInst
    localparam int L = (g == 0) ? 1 : 4;
    logic [7:0] mem  [256];
    logic [7:0] pipe [1:7];

    nrisc_mem_arbiter_if #(.W_ADDR(8), .W_DATA(8)) bus ();

    nrisc_mem_arbiter #(.LAT(L), .W_ADDR(8), .W_DATA(8)) dut (
      .clock  (clock),
      .reset_n(rstN[g]),
      .bus    (bus)
    );

    assign bus.if_req    = ifReq[g];
    assign bus.if_addr   = ifAddr[g];
    assign bus.dm_rd     = dmRd[g];
    assign bus.dm_wr     = dmWr[g];
    assign bus.dm_addr   = dmAddr[g];
    assign bus.dm_wdata  = dmWdata[g];
    assign bus.encerra   = enc[g];
    assign bus.mem_rdata = pipe[L];

    assign ifValidV[g]  = bus.if_valid;
    assign dmDoneV[g]   = bus.dm_done;
    assign haltedV[g]   = bus.halted;
    assign stallV[g]    = bus.stall;
    assign protoErrV[g] = bus.proto_err;
    assign memEnV[g]    = bus.mem_en;
    assign memWeV[g]    = bus.mem_we;
    assign ifRdataV[g]  = bus.if_rdata;
    assign dmRdataV[g]  = bus.dm_rdata;
    assign memAddrV[g]  = bus.mem_addr;

    initial for (int k = 0; k < 256; k++) mem[k] = initVal(8'(k));

    // Read data is valid only in the single cycle LAT after the strobe; 0xEE elsewhere.
    always @(posedge clock) begin
      pipe[1] <= bus.mem_en ? mem[bus.mem_addr] : 8'hEE;
      for (int k = 2; k <= 7; k++) pipe[k] <= pipe[k-1];
      if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
    end

    always @(negedge clock) begin
      obs_t o;
      o.rstN = rstN[g];  o.ifReq = ifReq[g]; o.dmRd = dmRd[g]; o.dmWr = dmWr[g];
      o.enc = enc[g];    o.ifAddr = ifAddr[g]; o.dmAddr = dmAddr[g]; o.dmWdata = dmWdata[g];
      o.ifValid = bus.if_valid; o.dmDone = bus.dm_done; o.halted = bus.halted;
      o.stall = bus.stall; o.protoErr = bus.proto_err; o.memEn = bus.mem_en;
      o.memWe = bus.mem_we; o.ifRdata = bus.if_rdata; o.dmRdata = bus.dm_rdata;
      o.memAddr = bus.mem_addr; o.memWdata = bus.mem_wdata;
      step(g, L, cyc, o);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic waitFor(input int i, input bit dm, input int budget, output int at);
    at = -1;
    for (int n = 0; n < budget; n++) begin
      @(negedge clock);
      if (dm ? dmDoneV[i] : ifValidV[i]) begin
        at = cyc;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL timeout inst%0d %s after %0d cycles", i, dm ? "dm_done" : "if_valid", budget);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, at, seen;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 256; k++) mdlMem[i][k] = initVal(8'(k));
    rstN = '0; ifReq = '0; dmRd = '0; dmWr = '0; enc = '0;
    for (int i = 0; i < 2; i++) begin
      ifAddr[i] = '0; dmAddr[i] = '0; dmWdata[i] = '0;
    end
    repeat (3) @(negedge clock);
    chk8("lit_rst_if_rdata", 0, ifRdataV[0], 8'h00);
    chk1("lit_rst_mem_en", 0, memEnV[0], 1'b0);
    tick();
    rstN = 2'b11;

    // 1: plain fetch, LAT=1
    tick();
    ifAddr[0] = 8'h10; ifReq[0] = 1'b1; t = cyc;
    #1 chk1("lit_t1_stall", 0, stallV[0], 1'b1);
    waitFor(0, 1'b0, 20, at);
    chkI("lit_t1_latency", at - t, 3);
    chk8("lit_t1_if_rdata", 0, ifRdataV[0], 8'hA5);
    tick();
    ifReq[0] = 1'b0;

    // 2: fetch and data read together; data first
    tick();
    ifAddr[0] = 8'h11; ifReq[0] = 1'b1; dmAddr[0] = 8'h20; dmRd[0] = 1'b1; t = cyc;
    waitFor(0, 1'b1, 20, at);
    chkI("lit_t2_dm_latency", at - t, 3);
    chk8("lit_t2_dm_rdata", 0, dmRdataV[0], 8'h3C);
    tick();
    dmRd[0] = 1'b0;
    waitFor(0, 1'b0, 20, at);
    chkI("lit_t2_if_latency", at - t, 7);
    chk8("lit_t2_if_rdata", 0, ifRdataV[0], 8'h4B);
    tick();
    ifReq[0] = 1'b0;

    // 3: write then read back
    tick();
    dmAddr[0] = 8'h05; dmWdata[0] = 8'h7E; dmWr[0] = 1'b1; t = cyc;
    tick();
    chk1("lit_t3_mem_we", 0, memWeV[0], 1'b1);
    waitFor(0, 1'b1, 20, at);
    chkI("lit_t3_wr_latency", at - t, 3);
    chk8("lit_t3_rdata_held", 0, dmRdataV[0], 8'h3C);
    tick();
    dmWr[0] = 1'b0; dmRd[0] = 1'b1;
    waitFor(0, 1'b1, 20, at);
    chk8("lit_t3_readback", 0, dmRdataV[0], 8'h7E);
    tick();
    dmRd[0] = 1'b0;

    // 5: halt raised mid-fetch
    tick();
    ifAddr[0] = 8'h12; ifReq[0] = 1'b1; t = cyc;
    tick();
    enc[0] = 1'b1;
    waitFor(0, 1'b0, 20, at);
    chkI("lit_t5_latency", at - t, 3);
    chk8("lit_t5_if_rdata", 0, ifRdataV[0], 8'h48);
    tick();
    ifReq[0] = 1'b0;
    tick();
    chk1("lit_t5_halted", 0, haltedV[0], 1'b1);
    ifAddr[0] = 8'h13; ifReq[0] = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clock);
      if (ifValidV[0]) seen++;
    end
    chkI("lit_t5_no_fetch", seen, 0);
    tick();
    dmAddr[0] = 8'h20; dmRd[0] = 1'b1; t = cyc;
    waitFor(0, 1'b1, 20, at);
    chkI("lit_t5_dm_latency", at - t, 3);
    chk8("lit_t5_dm_rdata", 0, dmRdataV[0], 8'h3C);
    tick();
    dmRd[0] = 1'b0; ifReq[0] = 1'b0;
    chk1("lit_t5_halted_end", 0, haltedV[0], 1'b1);
    enc[0] = 1'b0;

    // 6: read and write together -> write plus sticky error
    tick();
    dmAddr[0] = 8'h06; dmWdata[0] = 8'h99; dmRd[0] = 1'b1; dmWr[0] = 1'b1;
    waitFor(0, 1'b1, 20, at);
    chk8("lit_t6_rdata_held", 0, dmRdataV[0], 8'h3C);
    chk1("lit_t6_proto_err", 0, protoErrV[0], 1'b1);
    tick();
    dmWr[0] = 1'b0;
    waitFor(0, 1'b1, 20, at);
    chk8("lit_t6_readback", 0, dmRdataV[0], 8'h99);
    chk1("lit_t6_proto_sticky", 0, protoErrV[0], 1'b1);
    tick();
    dmRd[0] = 1'b0;
    tick();
    rstN[0] = 1'b0;
    #1 chk1("lit_t6_proto_cleared", 0, protoErrV[0], 1'b0);
    tick();
    rstN[0] = 1'b1;

    // 4: LAT=4, reset while waiting, then a fresh fetch
    tick();
    ifAddr[1] = 8'h40; ifReq[1] = 1'b1;
    tick();
    tick();
    rstN[1] = 1'b0;
    #1;
    chk8("lit_t4_mem_addr", 1, memAddrV[1], 8'h00);
    chk1("lit_t4_mem_en", 1, memEnV[1], 1'b0);
    chk1("lit_t4_mem_we", 1, memWeV[1], 1'b0);
    ifReq[1] = 1'b0;
    tick();
    rstN[1] = 1'b1; ifReq[1] = 1'b1; t = cyc;
    waitFor(1, 1'b0, 30, at);
    chkI("lit_t4_latency", at - t, 6);
    chk8("lit_t4_if_rdata", 1, ifRdataV[1], 8'h4D);
    tick();
    ifReq[1] = 1'b0;

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
